pq_arbiter: RTL and testbench
=============================

# pq_arbiter

Round-robin access controller sharing one hardware priority queue among NUM_CLIENTS requesters. It accepts enqueue/dequeue requests carrying `kv_t` pairs from `pq_pkg` and serializes them onto the single PQ operation port. It tracks occupancy to reject overflow and underflow without touching the queue, and returns dequeued pairs and ack/error status to the granted client. It sits between client logic and any HWPQ implementation built on `pq_pkg`.

## Interface
- NUM_CLIENTS, 4, number of requesters (2..16)
- CAP, pq_pkg::PQ_CAPACITY, queue capacity; CW = $clog2(CAP+1)
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cl_req  in  NUM_CLIENTS  per-client request, held until ack
- cl_op  in  NUM_CLIENTS  per-client op: 0=enqueue, 1=dequeue
- cl_kvin  in  NUM_CLIENTS x kv_t  per-client enqueue pair
- cl_ack  out  NUM_CLIENTS  one-hot, one-cycle completion pulse
- cl_err  out  1  valid with ack: op rejected (full enq / empty deq)
- cl_kvout  out  kv_t  valid with ack on successful dequeue
- pq_enq, pq_deq  out  1  one-cycle operation strobes to PQ
- pq_kvin  out  kv_t  enqueue data to PQ, valid with pq_enq
- pq_kvout  in  kv_t  PQ head pair, valid while !pq_busy and nonempty
- pq_busy  in  1  PQ operation in progress
- count  out  CW  current occupancy
- full, empty  out  1  count==CAP, count==0

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any cl_req, grant g = first requesting index at or after rr_ptr, wrapping modulo NUM_CLIENTS. Latch g, cl_op[g], cl_kvin[g].
  - Enq with full, or deq with empty: set err and go to RESP.
  - Otherwise, if pq_busy go to WAIT; else go to ISSUE.
- ISSUE: assert pq_enq or pq_deq for exactly one cycle and drive pq_kvin. On deq, capture pq_kvout this cycle. Go to WAIT.
- WAIT: stay while pq_busy; go to RESP on the first cycle with pq_busy=0.
- RESP: drive cl_ack[g]=1, cl_err, cl_kvout (captured pair on deq; KV_EMPTY on enq or error).
  - At the clock edge ending RESP: count +1 on successful enq, -1 on successful deq, unchanged on error; rr_ptr = (g+1) mod NUM_CLIENTS. Go to IDLE.
- A request withdrawn before grant is ignored. A request still high in the IDLE cycle after ack is treated as a new request.
- cl_op and cl_kvin are sampled only in IDLE; changes while granted have no effect.
- count never exceeds CAP and never underflows.

## Timing
- Reset values: state IDLE; rr_ptr 0; count 0; empty 1; full 0; cl_ack 0; cl_err 0; cl_kvout KV_EMPTY; pq_enq 0; pq_deq 0; pq_kvin KV_EMPTY.
- Successful op, PQ not busy: req sampled in IDLE at cycle t; ISSUE t+1; WAIT t+2 (or longer while pq_busy); earliest ack t+3.
- Rejected op: ack+err at t+1; no PQ strobe issued.
- count, full and empty update the cycle after ack.
- At most one PQ strobe per transaction. Strobes never overlap pq_busy=1.
- Reset mid-transaction: everything returns to reset values immediately; the in-flight op is dropped with no ack.

## Configuration
- PQ_ARB_STATS_EN defined: adds outputs stat_enq, stat_deq, stat_rej (16 bits each, reset 0, saturating at 0xFFFF). They increment at the RESP edge for successful enq, successful deq and rejected op respectively.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset, then client 0 enq K=5 V=1 -> pq_enq pulse with pq_kvin {5,1}, ack[0] at t+3, err=0, count=1.
- Fill to CAP=4, then client 2 enq -> ack[2]+err at t+1, no pq_enq, count stays 4, full=1.
- From empty, client 1 deq -> ack[1], err=1, cl_kvout=KV_EMPTY, no pq_deq.
- Clients 0,1,3 request simultaneously and hold -> acks granted in order 0,1,3, then 0 again if still held.
- Enq keys 9,3,7 then three deqs with a 3-cycle pq_busy model -> cl_kvout keys 3,7,9 (MIN_PQ); each ack arrives after busy falls.
- Assert rst_n=0 during WAIT -> all outputs at reset values, count=0, no ack; next request serviced normally.

Source files
------------

// File: rtl/pq_pkg.sv
// rtl/pq_pkg.sv - key/value pair type and queue constants shared by HWPQ blocks
package pq_pkg;

   localparam int KEY_W       = 8;
   localparam int VAL_W       = 8;
   localparam int PQ_CAPACITY = 4;

   typedef struct packed {
      logic [KEY_W-1:0] key;
      logic [VAL_W-1:0] value;
   } kv_t;

   // Sentinel pair: largest key, zero value, never a real MIN_PQ head
   localparam kv_t KV_EMPTY = '{key: '1, value: '0};

endpackage

// File: rtl/pq_arbiter.sv
// rtl/pq_arbiter.sv - round-robin arbiter sharing one priority queue; optional PQ_ARB_STATS_EN counters
module pq_arbiter #(
   parameter  int NUM_CLIENTS = 4,
   parameter  int CAP         = pq_pkg::PQ_CAPACITY,
   localparam int CW          = $clog2(CAP + 1)
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_CLIENTS-1:0]               cl_req,
   input  logic [NUM_CLIENTS-1:0]               cl_op,
   input  pq_pkg::kv_t [NUM_CLIENTS-1:0]        cl_kvin,
   output logic [NUM_CLIENTS-1:0]               cl_ack,
   output logic                                 cl_err,
   output pq_pkg::kv_t                          cl_kvout,
   output logic                                 pq_enq,
   output logic                                 pq_deq,
   output pq_pkg::kv_t                          pq_kvin,
   input  pq_pkg::kv_t                          pq_kvout,
   input  logic                                 pq_busy,
   output logic [CW-1:0]                        count,
   output logic                                 full,
   output logic                                 empty
`ifdef PQ_ARB_STATS_EN
   ,
   output logic [15:0]                          stat_enq,
   output logic [15:0]                          stat_deq,
   output logic [15:0]                          stat_rej
`endif
);

   import pq_pkg::*;

   localparam int PW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t                  state_q,    state_d;
   logic [PW-1:0]           rr_ptr_q,   rr_ptr_d;
   logic [PW-1:0]           g_q,        g_d;
   logic                    op_q,       op_d;
   kv_t                     kv_q,       kv_d;
   kv_t                     kv_cap_q,   kv_cap_d;
   logic                    issued_q,   issued_d;
   logic                    rej_q,      rej_d;
   logic [CW-1:0]           count_q,    count_d;
   logic [NUM_CLIENTS-1:0]  cl_ack_q,   cl_ack_d;
   logic                    cl_err_q,   cl_err_d;
   kv_t                     cl_kvout_q, cl_kvout_d;
   logic                    pq_enq_q,   pq_enq_d;
   logic                    pq_deq_q,   pq_deq_d;
   kv_t                     pq_kvin_q,  pq_kvin_d;

`ifdef PQ_ARB_STATS_EN
   logic [15:0]             stat_enq_q, stat_enq_d;
   logic [15:0]             stat_deq_q, stat_deq_d;
   logic [15:0]             stat_rej_q, stat_rej_d;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction
`endif

   logic                    any_req;
   logic [PW-1:0]           grant;
   logic                    cnt_full;
   logic                    cnt_empty;
   logic                    reject;

   assign any_req   = |cl_req;
   assign cnt_full  = (count_q == CW'(CAP));
   assign cnt_empty = (count_q == '0);
   assign reject    = cl_op[grant] ? cnt_empty : cnt_full;

   // Round-robin pick: first requester at or after rr_ptr, wrapping
   always_comb begin
      int  s;
      logic found;
      grant = rr_ptr_q;
      found = 1'b0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         s = int'(rr_ptr_q) + i;
         if (s >= NUM_CLIENTS) s = s - NUM_CLIENTS;
         if (!found && cl_req[PW'(s)]) begin
            found = 1'b1;
            grant = PW'(s);
         end
      end
   end

   // Transaction sequencing, occupancy tracking and registered outputs
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      g_d        = g_q;
      op_d       = op_q;
      kv_d       = kv_q;
      kv_cap_d   = kv_cap_q;
      issued_d   = issued_q;
      rej_d      = rej_q;
      count_d    = count_q;
      cl_ack_d   = '0;
      cl_err_d   = 1'b0;
      cl_kvout_d = KV_EMPTY;
      pq_enq_d   = 1'b0;
      pq_deq_d   = 1'b0;
      pq_kvin_d  = KV_EMPTY;
`ifdef PQ_ARB_STATS_EN
      stat_enq_d = stat_enq_q;
      stat_deq_d = stat_deq_q;
      stat_rej_d = stat_rej_q;
`endif
      case (state_q)
         IDLE: begin
            if (any_req) begin
               g_d      = grant;
               op_d     = cl_op[grant];
               kv_d     = cl_kvin[grant];
               rej_d    = reject;
               issued_d = 1'b0;
               if (reject) begin
                  // Overflow/underflow is answered locally; the queue is never touched
                  state_d  = RESP;
                  cl_ack_d = NUM_CLIENTS'(1) << grant;
                  cl_err_d = 1'b1;
               end else if (pq_busy) begin
                  state_d = WAIT;
               end else begin
                  state_d   = ISSUE;
                  issued_d  = 1'b1;
                  pq_enq_d  = ~cl_op[grant];
                  pq_deq_d  = cl_op[grant];
                  pq_kvin_d = cl_op[grant] ? KV_EMPTY : cl_kvin[grant];
               end
            end
         end
         ISSUE: begin
            // Head pair is still the pre-dequeue value during the strobe cycle
            if (op_q) kv_cap_d = pq_kvout;
            state_d = WAIT;
         end
         WAIT: begin
            if (!pq_busy) begin
               if (issued_q) begin
                  state_d    = RESP;
                  cl_ack_d   = NUM_CLIENTS'(1) << g_q;
                  cl_kvout_d = op_q ? kv_cap_q : KV_EMPTY;
               end else begin
                  // Queue was busy at grant time: strobe only once it has gone idle
                  state_d   = ISSUE;
                  issued_d  = 1'b1;
                  pq_enq_d  = ~op_q;
                  pq_deq_d  = op_q;
                  pq_kvin_d = op_q ? KV_EMPTY : kv_q;
               end
            end
         end
         RESP: begin
            if (!rej_q) begin
               if (op_q) count_d = count_q - 1'b1;
               else      count_d = count_q + 1'b1;
            end
`ifdef PQ_ARB_STATS_EN
            if (rej_q)     stat_rej_d = sat_inc(stat_rej_q);
            else if (op_q) stat_deq_d = sat_inc(stat_deq_q);
            else           stat_enq_d = sat_inc(stat_enq_q);
`endif
            rr_ptr_d = (int'(g_q) == NUM_CLIENTS - 1) ? '0 : g_q + 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset drops any in-flight transaction without an ack
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         g_q        <= '0;
         op_q       <= 1'b0;
         kv_q       <= KV_EMPTY;
         kv_cap_q   <= KV_EMPTY;
         issued_q   <= 1'b0;
         rej_q      <= 1'b0;
         count_q    <= '0;
         cl_ack_q   <= '0;
         cl_err_q   <= 1'b0;
         cl_kvout_q <= KV_EMPTY;
         pq_enq_q   <= 1'b0;
         pq_deq_q   <= 1'b0;
         pq_kvin_q  <= KV_EMPTY;
`ifdef PQ_ARB_STATS_EN
         stat_enq_q <= '0;
         stat_deq_q <= '0;
         stat_rej_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         g_q        <= g_d;
         op_q       <= op_d;
         kv_q       <= kv_d;
         kv_cap_q   <= kv_cap_d;
         issued_q   <= issued_d;
         rej_q      <= rej_d;
         count_q    <= count_d;
         cl_ack_q   <= cl_ack_d;
         cl_err_q   <= cl_err_d;
         cl_kvout_q <= cl_kvout_d;
         pq_enq_q   <= pq_enq_d;
         pq_deq_q   <= pq_deq_d;
         pq_kvin_q  <= pq_kvin_d;
`ifdef PQ_ARB_STATS_EN
         stat_enq_q <= stat_enq_d;
         stat_deq_q <= stat_deq_d;
         stat_rej_q <= stat_rej_d;
`endif
      end
   end

   assign cl_ack   = cl_ack_q;
   assign cl_err   = cl_err_q;
   assign cl_kvout = cl_kvout_q;
   assign pq_enq   = pq_enq_q;
   assign pq_deq   = pq_deq_q;
   assign pq_kvin  = pq_kvin_q;
   assign count    = count_q;
   assign full     = cnt_full;
   assign empty    = cnt_empty;
`ifdef PQ_ARB_STATS_EN
   assign stat_enq = stat_enq_q;
   assign stat_deq = stat_deq_q;
   assign stat_rej = stat_rej_q;
`endif

endmodule

// File: tb/tb_pq_arbiter.sv
// tb/tb_pq_arbiter.sv - directed self-checking bench for pq_arbiter with a MIN_PQ model
module tb_pq_arbiter;
   import pq_pkg::*;

   localparam int N  = 4;
   localparam int CW = $clog2(PQ_CAPACITY + 1);

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    cl_req;
   logic [N-1:0]    cl_op;
   kv_t [N-1:0]     cl_kvin;
   logic [N-1:0]    cl_ack;
   logic            cl_err;
   kv_t             cl_kvout;
   logic            pq_enq;
   logic            pq_deq;
   kv_t             pq_kvin;
   kv_t             pq_head;
   logic            pq_busy;
   logic [CW-1:0]   count;
   logic            full;
   logic            empty;
`ifdef PQ_ARB_STATS_EN
   logic [15:0]     stat_enq, stat_deq, stat_rej;
`endif

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   pq_arbiter #(.NUM_CLIENTS(N), .CAP(PQ_CAPACITY)) dut (
      .clk(clk), .rst_n(rst_n), .cl_req(cl_req), .cl_op(cl_op), .cl_kvin(cl_kvin),
      .cl_ack(cl_ack), .cl_err(cl_err), .cl_kvout(cl_kvout),
      .pq_enq(pq_enq), .pq_deq(pq_deq), .pq_kvin(pq_kvin), .pq_kvout(pq_head),
      .pq_busy(pq_busy), .count(count), .full(full), .empty(empty)
`ifdef PQ_ARB_STATS_EN
      , .stat_enq(stat_enq), .stat_deq(stat_deq), .stat_rej(stat_rej)
`endif
   );

   // MIN_PQ model: sorted store, head pair, busy for busy_len cycles after a strobe
   kv_t pq_mem[$];
   int  busy_len = 0;
   int  busy_cnt;
   assign pq_busy = (busy_cnt != 0);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pq_mem.delete();
         busy_cnt <= 0;
         pq_head  <= KV_EMPTY;
      end else begin
         if (pq_enq) begin
            int pos;
            pos = pq_mem.size();
            for (int i = pq_mem.size() - 1; i >= 0; i--)
               if (pq_kvin.key < pq_mem[i].key) pos = i;
            pq_mem.insert(pos, pq_kvin);
         end
         if (pq_deq && pq_mem.size() > 0) void'(pq_mem.pop_front());
         pq_head <= (pq_mem.size() > 0) ? pq_mem[0] : KV_EMPTY;
         if (pq_enq || pq_deq)  busy_cnt <= busy_len;
         else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
      end
   end

   // Strobe bookkeeping across the whole run
   int enq_strobes = 0, deq_strobes = 0, overlap = 0;
   always @(posedge clk) begin
      if (pq_enq) enq_strobes++;
      if (pq_deq) deq_strobes++;
      if ((pq_enq || pq_deq) && pq_busy) overlap++;
   end

   function automatic kv_t mk(input int k, input int v);
      kv_t r;
      r.key   = k[7:0];
      r.value = v[7:0];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One request from client c, held until ack; checks latency, status, strobes, occupancy
   task automatic run(input int c, input logic op, input kv_t kv, input int exp_lat,
                      input logic exp_err, input kv_t exp_kvo, input int exp_count);
      int   lat;
      logic err, s_enq, s_deq, busy_ack;
      kv_t  kvo, kvin_seen;
      lat = 0; err = 1'bx; busy_ack = 1'bx; kvo = KV_EMPTY; kvin_seen = KV_EMPTY;
      s_enq = 1'b0; s_deq = 1'b0;
      @(negedge clk);
      cl_req[c] = 1'b1; cl_op[c] = op; cl_kvin[c] = kv;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (pq_enq) begin s_enq = 1'b1; kvin_seen = pq_kvin; end
         if (pq_deq) s_deq = 1'b1;
         if (cl_ack != '0) begin
            lat = n; err = cl_err; kvo = cl_kvout; busy_ack = pq_busy;
            chk($sformatf("c%0d_ack_vec", c), cl_ack, N'(1) << c);
            break;
         end
      end
      cl_req[c] = 1'b0;
      chk($sformatf("c%0d_latency", c), lat, exp_lat);
      chk($sformatf("c%0d_err", c), err, exp_err);
      chk($sformatf("c%0d_kvout", c), kvo, exp_kvo);
      chk($sformatf("c%0d_busy_at_ack", c), busy_ack, 1'b0);
      chk($sformatf("c%0d_enq_strobe", c), s_enq, !op && !exp_err);
      chk($sformatf("c%0d_deq_strobe", c), s_deq, op && !exp_err);
      if (s_enq) chk($sformatf("c%0d_pq_kvin", c), kvin_seen, kv);
      @(negedge clk);
      chk($sformatf("c%0d_count", c), count, exp_count);
      chk($sformatf("c%0d_full", c), full, exp_count == PQ_CAPACITY);
      chk($sformatf("c%0d_empty", c), empty, exp_count == 0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_count"}, count, 0);
      chk({tag, "_empty"}, empty, 1'b1);
      chk({tag, "_full"}, full, 1'b0);
      chk({tag, "_ack"}, cl_ack, 0);
      chk({tag, "_err"}, cl_err, 1'b0);
      chk({tag, "_kvout"}, cl_kvout, KV_EMPTY);
      chk({tag, "_pq_enq"}, pq_enq, 1'b0);
      chk({tag, "_pq_deq"}, pq_deq, 1'b0);
      chk({tag, "_pq_kvin"}, pq_kvin, KV_EMPTY);
   endtask

   initial begin
      logic [N-1:0] seq[$];
      logic [N-1:0] exp_seq[4];

      rst_n = 1'b0; cl_req = '0; cl_op = '0;
      for (int i = 0; i < N; i++) cl_kvin[i] = KV_EMPTY;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;

      // First enqueue, then fill to capacity
      run(0, 1'b0, mk(5, 1), 3, 1'b0, KV_EMPTY, 1);
      run(1, 1'b0, mk(6, 2), 3, 1'b0, KV_EMPTY, 2);
      run(2, 1'b0, mk(7, 3), 3, 1'b0, KV_EMPTY, 3);
      run(3, 1'b0, mk(8, 4), 3, 1'b0, KV_EMPTY, 4);
      // Enqueue while full is rejected at t+1 without a strobe
      run(2, 1'b0, mk(1, 1), 1, 1'b1, KV_EMPTY, 4);
      // Drain in key order
      run(0, 1'b1, KV_EMPTY, 3, 1'b0, mk(5, 1), 3);
      run(1, 1'b1, KV_EMPTY, 3, 1'b0, mk(6, 2), 2);
      run(2, 1'b1, KV_EMPTY, 3, 1'b0, mk(7, 3), 1);
      run(3, 1'b1, KV_EMPTY, 3, 1'b0, mk(8, 4), 0);
      // Dequeue while empty is rejected; second reject from client 3 puts rr_ptr back at 0
      run(1, 1'b1, KV_EMPTY, 1, 1'b1, KV_EMPTY, 0);
      run(3, 1'b1, KV_EMPTY, 1, 1'b1, KV_EMPTY, 0);

      // Clients 0,1,3 request together; 0 keeps holding through its first ack
      cl_op = '1;
      cl_req = 4'b1011;
      for (int n = 0; n < 20 && seq.size() < 4; n++) begin
         @(negedge clk);
         if (cl_ack != '0) begin
            seq.push_back(cl_ack);
            if (cl_ack[1]) cl_req[1] = 1'b0;
            if (cl_ack[3]) cl_req[3] = 1'b0;
            if (cl_ack[0] && seq.size() >= 4) cl_req[0] = 1'b0;
         end
      end
      cl_req = '0;
      exp_seq = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
      chk("rr_ack_count", seq.size(), 4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("rr_order_%0d", i), (i < seq.size()) ? seq[i] : '0, exp_seq[i]);
      @(negedge clk);

      // Slow queue: three busy cycles per operation, acks only after busy falls
      busy_len = 3;
      run(0, 1'b0, mk(9, 1), 6, 1'b0, KV_EMPTY, 1);
      run(0, 1'b0, mk(3, 2), 6, 1'b0, KV_EMPTY, 2);
      run(0, 1'b0, mk(7, 3), 6, 1'b0, KV_EMPTY, 3);
      run(1, 1'b1, KV_EMPTY, 6, 1'b0, mk(3, 2), 2);
      run(1, 1'b1, KV_EMPTY, 6, 1'b0, mk(7, 3), 1);
      run(1, 1'b1, KV_EMPTY, 6, 1'b0, mk(9, 1), 0);

      // Reset while a transaction waits on the queue
      busy_len = 0;
      run(0, 1'b0, mk(4, 4), 3, 1'b0, KV_EMPTY, 1);
      busy_len = 3;
      @(negedge clk);
      cl_req[0] = 1'b1; cl_op[0] = 1'b0; cl_kvin[0] = mk(2, 5);
      @(negedge clk);
      chk("midrst_issue_strobe", pq_enq, 1'b1);
      @(negedge clk);
      chk("midrst_busy", pq_busy, 1'b1);
      chk("midrst_no_ack_yet", cl_ack, 0);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      cl_req[0] = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("midrst_ack_held", cl_ack, 0);
      end
      rst_n = 1'b1;
      busy_len = 0;
      run(2, 1'b0, mk(2, 2), 3, 1'b0, KV_EMPTY, 1);

`ifdef PQ_ARB_STATS_EN
      chk("stat_enq", stat_enq, 1);
      chk("stat_deq", stat_deq, 0);
      chk("stat_rej", stat_rej, 0);
`endif
      chk("strobe_overlap", overlap, 0);
      chk("enq_strobes", enq_strobes, 10);
      chk("deq_strobes", deq_strobes, 7);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
